// File: rtl/mdio_controller_pkg.sv
// Shared definitions for the MDIO management controller: sequencer states,
// opcodes, frame geometry and field positions of the 32-bit frame word.
package mdio_controller_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREAMBLE  = 3'd1,
        FRAME     = 3'd2,
        READ_DATA = 3'd3,
        DONE      = 3'd4
    } mdio_state_t;

    // Clause-22 opcodes.
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Frame geometry, in MDC bit periods.
    localparam int PREAMBLE_LEN    = 32;
    localparam int FRAME_LEN       = 32;
    localparam int READ_DRIVE_BITS = 14;
    localparam int READ_TA_BITS    = 2;
    localparam int RD_WIDTH        = 16;
    localparam int CNT_W           = 5;

    // Field positions inside the frame word.
    localparam int FLD_ST_MSB     = 31;
    localparam int FLD_ST_LSB     = 30;
    localparam int FLD_OP_MSB     = 29;
    localparam int FLD_OP_LSB     = 28;
    localparam int FLD_PHYADR_MSB = 27;
    localparam int FLD_PHYADR_LSB = 23;
    localparam int FLD_REGADR_MSB = 22;
    localparam int FLD_REGADR_LSB = 18;
    localparam int FLD_TA_MSB     = 17;
    localparam int FLD_TA_LSB     = 16;
    localparam int FLD_DATA_MSB   = 15;
    localparam int FLD_DATA_LSB   = 0;

    // Bit-counter landmarks derived from the geometry above.
    localparam logic [CNT_W-1:0] PREAMBLE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST      = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] READ_DRIVE_LAST = CNT_W'(READ_DRIVE_BITS - 1);
    localparam logic [CNT_W-1:0] READ_TURN_BIT   = CNT_W'(READ_DRIVE_BITS);
    localparam logic [CNT_W-1:0] READ_DATA_FIRST = CNT_W'(READ_DRIVE_BITS + READ_TA_BITS);

    // Frame bit number idx (0 = first on the wire) of an MSB-first frame word.
    function automatic logic frame_bit(input logic [FRAME_LEN-1:0] frame,
                                       input logic [CNT_W-1:0]     idx);
        logic [CNT_W-1:0] pos_v;
        pos_v = FRAME_LAST - idx;
        return frame[pos_v];
    endfunction

endpackage

// File: rtl/mdio_shift_rx.sv
// Serial-in receive shifter for MDIO read data. Bits enter at the LSB so the
// first received bit ends up as the MSB; the published word only changes on
// load_out, so it holds across write transactions.
module mdio_shift_rx
    import mdio_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                load_out,
    input  logic                sdin,
    output logic [RD_WIDTH-1:0] data_out
);

    logic [RD_WIDTH-1:0] shift_r;
    logic [RD_WIDTH-1:0] shift_next_s;
    logic [RD_WIDTH-1:0] data_out_r;

    // Next shifter contents; publishing on the last bit uses this so the final bit is included.
    always_comb begin
        shift_next_s = shift_r;
        if (shift_en) begin
            shift_next_s = {shift_r[RD_WIDTH-2:0], sdin};
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Shift register and published word, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {RD_WIDTH{1'b0}};
            data_out_r <= {RD_WIDTH{1'b0}};
        end else begin
            shift_r <= shift_next_s;
            if (load_out) begin
                data_out_r <= shift_next_s;
            end
        end
    end

    assign data_out = data_out_r;

endmodule

// File: rtl/mdio_controller.sv
// MDIO management controller. Sends a 32-bit preamble of ones followed by the
// latched frame word, MSB first, one bit per two CLK (MDC low then MDC high).
// Reads release the line after REGADR, skip the turnaround and shift in
// 16 data bits sampled at the end of each MDC-high cycle.
module mdio_controller
    import mdio_controller_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 MDIO_START,
    input  logic [FRAME_LEN-1:0] T_DATA,
    input  logic                 MDIO_IN,
    output logic                 MDC,
    output logic                 MDIO_OE,
    output logic                 MDIO_OUT,
    output logic [RD_WIDTH-1:0]  RD_DATA,
    output logic                 DATA_RDY,
    output logic                 BUSY
);

    mdio_state_t          state_r;
    logic [FRAME_LEN-1:0] frame_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic                 mdc_r;
    logic                 oe_r;
    logic                 out_r;
    logic                 busy_r;
    logic                 rdy_r;
    logic                 shift_en_s;
    logic                 load_s;
    logic                 is_read_s;

    assign is_read_s = (frame_r[FLD_OP_MSB:FLD_OP_LSB] == OP_READ);

    // Main sequencer: bit timing, MDC generation and every registered output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            frame_r   <= 32'h0000_0000;
            bit_cnt_r <= 5'd0;
            mdc_r     <= 1'b0;
            oe_r      <= 1'b0;
            out_r     <= 1'b0;
            busy_r    <= 1'b0;
            rdy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mdc_r     <= 1'b0;
                    oe_r      <= 1'b0;
                    out_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    rdy_r     <= 1'b0;
                    bit_cnt_r <= 5'd0;
                    if (MDIO_START) begin
                        frame_r <= T_DATA;
                        busy_r  <= 1'b1;
                        oe_r    <= 1'b1;
                        out_r   <= 1'b1;
                        state_r <= PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    rdy_r <= 1'b0;
                    if (mdc_r == 1'b0) begin
                        mdc_r <= 1'b1;
                    end else if (bit_cnt_r == PREAMBLE_LAST) begin
                        mdc_r     <= 1'b0;
                        bit_cnt_r <= 5'd0;
                        out_r     <= frame_bit(frame_r, 5'd0);
                        state_r   <= FRAME;
                    end else begin
                        mdc_r     <= 1'b0;
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        out_r     <= 1'b1;
                    end
                end

                FRAME: begin
                    rdy_r <= 1'b0;
                    if (mdc_r == 1'b0) begin
                        mdc_r <= 1'b1;
                    end else if (bit_cnt_r == FRAME_LAST) begin
                        mdc_r   <= 1'b0;
                        oe_r    <= 1'b0;
                        out_r   <= 1'b0;
                        state_r <= DONE;
                    end else if (is_read_s && (bit_cnt_r == READ_DRIVE_LAST)) begin
                        // Release the line on the MDC-low half of the first TA bit.
                        mdc_r     <= 1'b0;
                        oe_r      <= 1'b0;
                        out_r     <= 1'b0;
                        bit_cnt_r <= READ_TURN_BIT;
                        state_r   <= READ_DATA;
                    end else begin
                        mdc_r     <= 1'b0;
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        out_r     <= frame_bit(frame_r, bit_cnt_r + 5'd1);
                    end
                end

                READ_DATA: begin
                    oe_r  <= 1'b0;
                    out_r <= 1'b0;
                    if (mdc_r == 1'b0) begin
                        mdc_r <= 1'b1;
                        rdy_r <= 1'b0;
                    end else if (bit_cnt_r == FRAME_LAST) begin
                        mdc_r   <= 1'b0;
                        rdy_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        mdc_r     <= 1'b0;
                        rdy_r     <= 1'b0;
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end
                end

                DONE: begin
                    mdc_r     <= 1'b0;
                    oe_r      <= 1'b0;
                    out_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    rdy_r     <= 1'b0;
                    bit_cnt_r <= 5'd0;
                    state_r   <= IDLE;
                end

                default: begin
                    mdc_r     <= 1'b0;
                    oe_r      <= 1'b0;
                    out_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    rdy_r     <= 1'b0;
                    bit_cnt_r <= 5'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Receive shifter controls: shift at the end of each MDC-high data bit, publish on the last.
    always_comb begin
        shift_en_s = 1'b0;
        load_s     = 1'b0;
        if ((state_r == READ_DATA) && (mdc_r == 1'b1) && (bit_cnt_r >= READ_DATA_FIRST)) begin
            shift_en_s = 1'b1;
            load_s     = (bit_cnt_r == FRAME_LAST);
        end else begin
            shift_en_s = 1'b0;
            load_s     = 1'b0;
        end
    end

    mdio_shift_rx u_shift_rx (
        .clk      (CLK),
        .rst      (RESET),
        .shift_en (shift_en_s),
        .load_out (load_s),
        .sdin     (MDIO_IN),
        .data_out (RD_DATA)
    );

    assign MDC      = mdc_r;
    assign MDIO_OE  = oe_r;
    assign MDIO_OUT = out_r;
    assign DATA_RDY = rdy_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_mdio_controller.sv
// Directed self-checking bench for mdio_controller. Cycle c of a transaction
// is the CLK period after accept edge E0+c; outputs are recorded on the
// falling edge inside that period and inputs are driven there as well.
module tb_mdio_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MDIO_START = 1'b0;
    logic [31:0] T_DATA = 32'h0000_0000;
    logic        MDIO_IN = 1'b1;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    logic        mdc_a  [0:299];
    logic        oe_a   [0:299];
    logic        out_a  [0:299];
    logic        busy_a [0:299];
    logic        rdy_a  [0:299];
    logic [15:0] rd_a   [0:299];

    always #5 CLK = ~CLK;

    mdio_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDC        (MDC),
        .MDIO_OE    (MDIO_OE),
        .MDIO_OUT   (MDIO_OUT),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY),
        .BUSY       (BUSY)
    );

    // Record n cycles. START stays high for edges E0..E0+start_len-1, RESET is
    // sampled high at edge E0+rst_edge (0 = never). The PHY model drives read
    // bit i for the edge E0+98+2i and its complement one edge earlier.
    task automatic run_cycles(input int n, input int start_len, input int rst_edge,
                              input bit phy_en, input logic [15:0] phy_word);
        int   idx;
        logic bit_v;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            mdc_a[c]  = MDC;
            oe_a[c]   = MDIO_OE;
            out_a[c]  = MDIO_OUT;
            busy_a[c] = BUSY;
            rdy_a[c]  = DATA_RDY;
            rd_a[c]   = RD_DATA;
            MDIO_START = (c + 1 < start_len);
            RESET      = (c + 1 == rst_edge);
            if (phy_en && c >= 96 && c < 128) begin
                idx   = 15 - ((c - 96) / 2);
                bit_v = phy_word[idx];
                MDIO_IN = (c % 2 == 1) ? bit_v : ~bit_v;
            end else begin
                MDIO_IN = 1'b1;
            end
        end
    endtask

    task automatic launch(input logic [31:0] frame);
        @(negedge CLK);
        T_DATA     = frame;
        MDIO_START = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] got;
        @(negedge CLK);
        RESET = 1'b1;
        MDIO_START = 1'b1;
        T_DATA = 32'h5A3C_1234;
        @(negedge CLK);
        @(negedge CLK);
        got = {MDC, MDIO_OE, MDIO_OUT, BUSY, DATA_RDY, RD_DATA};
        n_cmp++;
        if (got !== 21'h000000) begin
            n_bad++;
            $display("FAIL reset_state: got %h required %h", got, 21'h000000);
        end
        RESET = 1'b0;
        MDIO_START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b required 0", BUSY);
        end
    endtask

    task automatic test_write();
        logic [63:0]  hi_v;
        logic [63:0]  lo_v;
        logic [127:0] mdc_v;
        logic [3:0]   done_v;
        int rises, oe_ones, first_idle, rdy_cnt;
        logic prev;
        launch(32'h5A3C_1234);
        run_cycles(140, 1, 0, 1'b0, 16'h0000);
        rises = 0; oe_ones = 0; first_idle = -1; rdy_cnt = 0; prev = 1'b0;
        for (int c = 0; c < 128; c++) begin
            mdc_v[c] = mdc_a[c];
            if (oe_a[c] === 1'b1) oe_ones++;
        end
        for (int b = 0; b < 64; b++) begin
            hi_v[63 - b] = out_a[2 * b + 1];
            lo_v[63 - b] = out_a[2 * b];
        end
        for (int c = 0; c < 140; c++) begin
            if (mdc_a[c] === 1'b1 && prev === 1'b0) rises++;
            prev = mdc_a[c];
            if (rdy_a[c] === 1'b1) rdy_cnt++;
            if (busy_a[c] === 1'b0 && first_idle < 0) first_idle = c;
        end
        done_v = {mdc_a[128], oe_a[128], out_a[128], busy_a[128]};
        n_cmp++;
        if (hi_v !== 64'hFFFF_FFFF_5A3C_1234) begin
            n_bad++; $display("FAIL wr_stream_mdc_high: got %h required %h", hi_v, 64'hFFFF_FFFF_5A3C_1234);
        end
        n_cmp++;
        if (lo_v !== 64'hFFFF_FFFF_5A3C_1234) begin
            n_bad++; $display("FAIL wr_stream_mdc_low: got %h required %h", lo_v, 64'hFFFF_FFFF_5A3C_1234);
        end
        n_cmp++;
        if (mdc_v !== {64{2'b10}}) begin
            n_bad++; $display("FAIL wr_mdc_pattern: got %h required %h", mdc_v, {64{2'b10}});
        end
        n_cmp++;
        if (oe_ones !== 128) begin
            n_bad++; $display("FAIL wr_oe_cycles: got %0d required 128", oe_ones);
        end
        n_cmp++;
        if (first_idle !== 129) begin
            n_bad++; $display("FAIL wr_busy_len: got %0d required 129", first_idle);
        end
        n_cmp++;
        if (done_v !== 4'b0001) begin
            n_bad++; $display("FAIL wr_done_outputs: got %b required 0001", done_v);
        end
        n_cmp++;
        if (rdy_cnt !== 0) begin
            n_bad++; $display("FAIL wr_no_data_rdy: got %0d required 0", rdy_cnt);
        end
        n_cmp++;
        if (rises !== 64) begin
            n_bad++; $display("FAIL wr_mdc_rises: got %0d required 64", rises);
        end
    endtask

    task automatic test_read();
        logic [45:0] drv_v;
        int rises, first_oe_low, out_ones, rdy_cnt, first_rdy, first_idle;
        logic prev;
        launch(32'h6000_0000);
        run_cycles(140, 1, 0, 1'b1, 16'h8FF1);
        rises = 0; first_oe_low = -1; out_ones = 0; rdy_cnt = 0; first_rdy = -1;
        first_idle = -1; prev = 1'b0;
        for (int b = 0; b < 46; b++) drv_v[45 - b] = out_a[2 * b + 1];
        for (int c = 0; c < 140; c++) begin
            if (mdc_a[c] === 1'b1 && prev === 1'b0) rises++;
            prev = mdc_a[c];
            if (oe_a[c] === 1'b0 && first_oe_low < 0) first_oe_low = c;
            if (c >= 92 && out_a[c] !== 1'b0) out_ones++;
            if (rdy_a[c] === 1'b1) begin
                rdy_cnt++;
                if (first_rdy < 0) first_rdy = c;
            end
            if (busy_a[c] === 1'b0 && first_idle < 0) first_idle = c;
        end
        n_cmp++;
        if (drv_v !== {32'hFFFF_FFFF, 14'b01100000000000}) begin
            n_bad++; $display("FAIL rd_driven_bits: got %h required %h", drv_v, {32'hFFFF_FFFF, 14'b01100000000000});
        end
        n_cmp++;
        if (first_oe_low !== 92) begin
            n_bad++; $display("FAIL rd_oe_release: got %0d required 92", first_oe_low);
        end
        n_cmp++;
        if (out_ones !== 0) begin
            n_bad++; $display("FAIL rd_out_low_while_released: got %0d required 0", out_ones);
        end
        n_cmp++;
        if (rd_a[127] !== 16'h0000) begin
            n_bad++; $display("FAIL rd_data_before_load: got %h required 0000", rd_a[127]);
        end
        n_cmp++;
        if (rd_a[128] !== 16'h8FF1) begin
            n_bad++; $display("FAIL rd_data_word: got %h required 8ff1", rd_a[128]);
        end
        n_cmp++;
        if (rdy_cnt !== 1 || first_rdy !== 128) begin
            n_bad++; $display("FAIL rd_data_rdy_pulse: got count %0d at %0d required 1 at 128", rdy_cnt, first_rdy);
        end
        n_cmp++;
        if (first_idle !== 129) begin
            n_bad++; $display("FAIL rd_busy_len: got %0d required 129", first_idle);
        end
        n_cmp++;
        if (rises !== 64) begin
            n_bad++; $display("FAIL rd_mdc_rises: got %0d required 64", rises);
        end
    endtask

    task automatic test_write_after_read();
        int rd_changed, rises, rdy_cnt;
        logic prev;
        launch(32'h5A3C_1234);
        run_cycles(140, 1, 0, 1'b0, 16'h0000);
        rd_changed = 0; rises = 0; rdy_cnt = 0; prev = 1'b0;
        for (int c = 0; c < 140; c++) begin
            if (rd_a[c] !== 16'h8FF1) rd_changed++;
            if (mdc_a[c] === 1'b1 && prev === 1'b0) rises++;
            prev = mdc_a[c];
            if (rdy_a[c] === 1'b1) rdy_cnt++;
        end
        n_cmp++;
        if (rd_changed !== 0) begin
            n_bad++; $display("FAIL war_rd_data_hold: got %0d cycles differing from 8ff1 required 0", rd_changed);
        end
        n_cmp++;
        if (rises !== 64) begin
            n_bad++; $display("FAIL war_mdc_rises: got %0d required 64", rises);
        end
        n_cmp++;
        if (rdy_cnt !== 0) begin
            n_bad++; $display("FAIL war_no_data_rdy: got %0d required 0", rdy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, second_rise, second_fall, rises;
        logic prev_b, prev_m;
        launch(32'h5A3C_1234);
        run_cycles(270, 200, 0, 1'b0, 16'h0000);
        accepts = 0; second_rise = -1; second_fall = -1; rises = 0;
        prev_b = 1'b0; prev_m = 1'b0;
        for (int c = 0; c < 270; c++) begin
            if (busy_a[c] === 1'b1 && prev_b === 1'b0) begin
                accepts++;
                if (accepts == 2) second_rise = c;
            end
            if (busy_a[c] === 1'b0 && prev_b === 1'b1 && accepts == 2 && second_fall < 0) second_fall = c;
            prev_b = busy_a[c];
            if (mdc_a[c] === 1'b1 && prev_m === 1'b0) rises++;
            prev_m = mdc_a[c];
        end
        n_cmp++;
        if (accepts !== 2) begin
            n_bad++; $display("FAIL b2b_transactions: got %0d required 2", accepts);
        end
        n_cmp++;
        if (second_rise !== 130) begin
            n_bad++; $display("FAIL b2b_second_accept: got %0d required 130", second_rise);
        end
        n_cmp++;
        if (second_fall !== 259) begin
            n_bad++; $display("FAIL b2b_second_end: got %0d required 259", second_fall);
        end
        n_cmp++;
        if (rises !== 128) begin
            n_bad++; $display("FAIL b2b_mdc_rises: got %0d required 128", rises);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [16:0] pre_v;
        logic [20:0] post_v;
        int rdy_cnt, busy_after;
        launch(32'h6000_0000);
        run_cycles(140, 1, 80, 1'b1, 16'h8FF1);
        rdy_cnt = 0; busy_after = 0;
        for (int c = 0; c < 140; c++) begin
            if (rdy_a[c] === 1'b1) rdy_cnt++;
            if (c >= 80 && busy_a[c] !== 1'b0) busy_after++;
        end
        pre_v  = {busy_a[79], rd_a[79]};
        post_v = {mdc_a[80], oe_a[80], out_a[80], busy_a[80], rdy_a[80], rd_a[80]};
        n_cmp++;
        if (pre_v !== {1'b1, 16'h8FF1}) begin
            n_bad++; $display("FAIL rst_mid_pre_state: got %h required %h", pre_v, {1'b1, 16'h8FF1});
        end
        n_cmp++;
        if (post_v !== 21'h000000) begin
            n_bad++; $display("FAIL rst_mid_outputs: got %h required %h", post_v, 21'h000000);
        end
        n_cmp++;
        if (rdy_cnt !== 0) begin
            n_bad++; $display("FAIL rst_mid_no_data_rdy: got %0d required 0", rdy_cnt);
        end
        n_cmp++;
        if (busy_after !== 0 || rd_a[139] !== 16'h0000) begin
            n_bad++; $display("FAIL rst_mid_stays_idle: got busy cycles %0d rd %h required 0 and 0000", busy_after, rd_a[139]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_write_after_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
